// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and
// the width of one arithmetic slice.
package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

endpackage

// File: rtl/nsa_nibble_add.sv
// Combinational 4-bit adder slice (a + b + cin -> s, cout).
// The top level reuses this one slice on a different nibble every RUN cycle.
module nsa_nibble_add
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W:0] total;

    // Full-width add so the carry falls out as the top bit
    assign total = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, cin};
    assign s     = total[NIBBLE_W-1:0];
    assign cout  = total[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: captures A and B on start, then adds one 4-bit slice
// per cycle, LSB first, through a single shared nsa_nibble_add. done pulses
// for one cycle when Sum/C4 are final; they stay put until the next start.
// Optional macro NSA_SUB_EN adds a 'sub' input selecting A - B
// (A + ~B + 1); C4 then reads as "no borrow".
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [4*NIBBLES-1:0]      A,
    input  logic [4*NIBBLES-1:0]      B,
`ifdef NSA_SUB_EN
    input  logic                      sub,
`endif
    output logic                      busy,
    output logic                      done,
    output logic [4*NIBBLES-1:0]      Sum,
    output logic                      C4
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    nsa_state_t           state;
    logic [IDX_W-1:0]     idx;
    logic                 carry;
    logic [W-1:0]         a_r;
    logic [W-1:0]         b_r;
    logic                 accept;
    logic                 cin_init;
    logic [W-1:0]         b_in;
    logic [NIBBLE_W-1:0]  slice_a;
    logic [NIBBLE_W-1:0]  slice_b;
    logic [NIBBLE_W-1:0]  slice_s;
    logic                 slice_cout;

    // A new operation is only taken when no addition is running
    assign accept = start && (state != RUN);

`ifdef NSA_SUB_EN
    // Subtraction is A + ~B + 1: invert B at capture and seed the carry
    assign b_in     = sub ? ~B : B;
    assign cin_init = sub;
`else
    assign b_in     = B;
    assign cin_init = 1'b0;
`endif

    assign slice_a = a_r[idx*NIBBLE_W +: NIBBLE_W];
    assign slice_b = b_r[idx*NIBBLE_W +: NIBBLE_W];

    nsa_nibble_add u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .s    (slice_s),
        .cout (slice_cout)
    );

    // Operand capture; pure data, so no reset is needed
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= A;
            b_r <= b_in;
        end
    end

    // Control FSM with registered busy/done and serial result assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            Sum   <= '0;
            C4    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        idx   <= '0;
                        carry <= cin_init;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    Sum[idx*NIBBLE_W +: NIBBLE_W] <= slice_s;
                    carry <= slice_cout;
                    idx   <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        C4    <= slice_cout;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NIBBLES=4). Stimulus pushes the hand-computed
// result and the cycle at which done must be seen; a monitor pops on every done.
// Build with +define+NSA_SUB_EN to also exercise subtraction.
module tb_nibble_serial_adder;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    typedef struct {
        logic [W-1:0] sum;
        logic         c4;
        int           cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] A;
    logic [W-1:0] B;
`ifdef NSA_SUB_EN
    logic         sub;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         C4;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
`ifdef NSA_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .C4    (C4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Issue one operation at the current negedge; done is due NIBBLES+1 cycles on
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] esum, input logic ec4);
        exp_t e;
        A     = a;
        B     = b;
        start = 1'b1;
        e.sum = esum;
        e.c4  = ec4;
        e.cyc = cyc + NIBBLES + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Monitor: sample just after each rising edge and score every done pulse
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_done: Sum=0x%0h C4=%0b with nothing expected (cycle %0d)", Sum, C4, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sum",     32'(Sum), 32'(e.sum));
                    chk("c4",      32'(C4),  32'(e.c4));
                    chk("latency", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
`ifdef NSA_SUB_EN
        sub   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sum",  32'(Sum),  32'd0);
        chk("rst_c4",   32'(C4),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Basic add, no carries
        issue(16'h1234, 16'h4321, 16'h5555, 1'b0);
        chk("busy_run", 32'(busy), 32'd1);
        repeat (NIBBLES + 3) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);

        // Carry ripples through every nibble and out
        issue(16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        repeat (NIBBLES + 3) @(negedge clk);

        // Mixed carries
        issue(16'hA5C3, 16'h1F2E, 16'hC4F1, 1'b0);
        repeat (NIBBLES + 3) @(negedge clk);

        // New start and operand changes while busy must be ignored
        issue(16'h1111, 16'h2222, 16'h3333, 1'b0);
        A     = 16'hAAAA;
        B     = 16'hAAAA;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A     = 16'h0000;
        B     = 16'h0000;
        repeat (NIBBLES + 3) @(negedge clk);

        // Reset in the 2nd RUN cycle: outputs clear at once, no done follows
        A     = 16'h0101;
        B     = 16'h0101;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort_busy_pre", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_sum",  32'(Sum),  32'd0);
        chk("abort_c4",   32'(C4),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (NIBBLES + 4) @(negedge clk);

        // Start held through DONE: back-to-back operations, second done 5 later
        begin
            exp_t e;
            A     = 16'h0F0F;
            B     = 16'h00F1;
            start = 1'b1;
            e.sum = 16'h1000;
            e.c4  = 1'b0;
            e.cyc = cyc + NIBBLES + 1;
            exp_q.push_back(e);
            e.cyc = cyc + 2 * (NIBBLES + 1);
            exp_q.push_back(e);
            repeat (NIBBLES + 2) @(negedge clk);
            start = 1'b0;
            repeat (NIBBLES + 3) @(negedge clk);
        end

`ifdef NSA_SUB_EN
        // Subtraction: borrow gives C4=0, no borrow gives C4=1
        sub = 1'b1;
        issue(16'h0005, 16'h0007, 16'hFFFE, 1'b0);
        sub = 1'b0;
        repeat (NIBBLES + 3) @(negedge clk);
        sub = 1'b1;
        issue(16'h0007, 16'h0005, 16'h0002, 1'b1);
        sub = 1'b0;
        repeat (NIBBLES + 3) @(negedge clk);
`endif

        chk("pending_results", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
